// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Holds the blank glyph, the blank nibble and the scan FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-low 7-segment decoder, segments A (MSB) .. G (LSB).
// Ports: nib_i = BCD nibble; seg_o = glyph, all off for 0xA..0xF.
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nib_i)
            4'h0:    seg_o = 7'b0000001;
            4'h1:    seg_o = 7'b1001111;
            4'h2:    seg_o = 7'b0010010;
            4'h3:    seg_o = 7'b0000110;
            4'h4:    seg_o = 7'b1001100;
            4'h5:    seg_o = 7'b0100100;
            4'h6:    seg_o = 7'b0100000;
            4'h7:    seg_o = 7'b0001111;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0000100;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode 7-segment scanner with a double-buffered word.
// Ports: clk/rst_n, load_valid/load_ready/load_data handshake, blank_lz,
// an (active-low anodes), seg (active-low A..G), frame_done pulse.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int CNT_MAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d;
    logic [DIGITS-1:0][3:0] pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   fd_q, fd_d;

    logic                   accept;
    logic                   wrap;
    logic                   lz_blank;
    logic [3:0]             nib;
    logic [6:0]             glyph;

    assign nib = disp_q[idx_q];

    bcd_to_7seg u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    // Blank when this digit and all more-significant digits are zero.
    always_comb begin
        lz_blank = blank_lz && (idx_q != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_q[j] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        wrap        = 1'b0;
        accept      = load_valid && !pend_full_q;

        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(GUARD - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                        // An accept can never coincide with this swap:
                        // accept needs the shadow to be empty.
                        if (pend_full_q) begin
                            disp_d      = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // idx and disp only move on DRIVE exit, so the current
        // values already describe the digit about to be driven.
        fd_d  = wrap;
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == ST_DRIVE) begin
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank ? SEG_OFF : glyph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            disp_q      <= {DIGITS{NIB_BLANK}};
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fd_q        <= fd_d;
        end
    end

    assign load_ready = !pend_full_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller (4 digits, PRESCALE=4, GUARD=1).
// Reference model derives the display from cycle count since reset release.
module tb_seg7_scan_controller;

    localparam int DIGITS = 4;
    localparam int SLOT   = 5;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;

    seg7_scan_controller #(
        .DIGITS   (4),
        .PRESCALE (4),
        .GUARD    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] w,
                                           input bit blz);
        logic [15:0] upper;
        upper = w >> (4 * d);
        if (blz && d != 0 && upper == 16'h0) exp_seg = 7'b1111111;
        else exp_seg = glyph(upper[3:0]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_disp = 16'hFFFF;
        m_pend = 16'h0;
        m_full = 1'b0;
    endtask

    // One clock: predict from pre-edge inputs, then compare at edge+1.
    task automatic step();
        bit          acc;
        bit          blz;
        logic [15:0] dat;
        int          m;
        int          d;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        acc = load_valid && !m_full;
        dat = load_data;
        blz = blank_lz;
        @(posedge clk);
        k++;
        if (k % FRAME == 0 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend = dat;
            m_full = 1'b1;
        end
        #1;
        m = k % SLOT;
        d = ((k - 1) / SLOT) % DIGITS;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        if (m != 0) begin
            e_an  = ~(4'b0001 << d);
            e_seg = exp_seg(d, m_disp, blz);
        end
        check("an", {12'h0, an}, {12'h0, e_an});
        check("seg", {9'h0, seg}, {9'h0, e_seg});
        check("frame_done", {15'h0, frame_done}, {15'h0, (k % FRAME == 0)});
        check("load_ready", {15'h0, load_ready}, {15'h0, !m_full});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] d);
        int n;
        n = 0;
        load_data  = d;
        load_valid = 1'b1;
        while (m_full && n < 100) begin
            step();
            n++;
        end
        check("load_stall_bound", {15'h0, m_full}, 16'h0);
        step();
        load_valid = 1'b0;
    endtask

    task automatic step_until(input int phase);
        int n;
        n = 0;
        while (k % FRAME != phase && n < 200) begin
            step();
            n++;
        end
        check("phase_bound", 16'(k % FRAME), 16'(phase));
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_ready", {15'h0, load_ready}, 16'h1);
        check("rst_fd", {15'h0, frame_done}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(FRAME + 3);

        load(16'h1234);
        run(3 * FRAME);

        blank_lz = 1'b1;
        load(16'h0050);
        run(2 * FRAME + 2);
        blank_lz = 1'b0;
        run(FRAME);

        load(16'h1111);
        load(16'h2222);
        run(3 * FRAME);

        load(16'h9A0F);
        run(2 * FRAME);
        blank_lz = 1'b1;
        run(FRAME);
        blank_lz = 1'b0;

        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step();
        end
        load_valid = 1'b0;
        blank_lz   = 1'b0;
        run(FRAME);

        step_until(1);
        load(16'h5678);
        load(16'h8888);
        step_until(12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", {12'h0, an}, 16'h000F);
        check("async_rst_seg", {9'h0, seg}, 16'h007F);
        check("async_rst_ready", {15'h0, load_ready}, 16'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
